// File: rtl/vx_smem_pkg.sv
// Shared types and sizing helpers for the shared-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vx_smem_pkg;

    localparam int SMEM_NUM_REQS       = 4;
    localparam int SMEM_WORD_SIZE      = 4;
    localparam int SMEM_TAG_WIDTH      = 8;
    localparam int SMEM_ADDR_WIDTH     = 30;
    localparam int SMEM_SIZE_WORDS     = 1024;
    localparam int SMEM_RSP_QUEUE_SIZE = 4;

    // Lane index width; a single-lane build still carries a 1-bit lane field.
    function automatic int lane_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SMEM_LANE_W = lane_idx_width(SMEM_NUM_REQS);
    localparam int SMEM_IDX_W  = $clog2(SMEM_SIZE_WORDS);

    typedef struct packed {
        logic [SMEM_LANE_W-1:0]      lane;
        logic [SMEM_TAG_WIDTH-1:0]   tag;
        logic [SMEM_WORD_SIZE*8-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/vx_smem_rsp_fifo.sv
// Response queue: DEPTH-entry FIFO of rsp_entry_t with a registered head entry.
// Latency: a push into an empty queue is visible on head the next cycle.
// Backpressure: caller must not push when full or pop when empty.
// Ports: clk/reset, push + push_data, pop, head (front entry), empty, full.
module vx_smem_rsp_fifo
    import vx_smem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output rsp_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);

    rsp_entry_t       store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic [PTR_W:0]   remain;
    rsp_entry_t       head_nxt;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        remain     = count - {{PTR_W{1'b0}}, pop};
        count_nxt  = remain + {{PTR_W{1'b0}}, push};
        head_nxt   = head;
        if (count_nxt != '0) begin
            // When nothing older survives this cycle, the incoming entry
            // becomes the head directly (store is only written at the edge).
            if (push && (remain == '0)) begin
                head_nxt = push_data;
            end else begin
                head_nxt = store[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/vx_smem_responder.sv
// Multi-lane scratchpad responder: round-robin grant of one lane per cycle into a single-port SRAM.
// Latency: writes commit at the accept edge; read responses appear 2 cycles after accept at the earliest.
// Backpressure: reads need a free response credit; a blocked granted read stalls all lanes that cycle.
// Ports: req_* per-lane request bundle with req_ready accept; rsp_* valid/ready response (lane, tag, data).
module vx_smem_responder
    import vx_smem_pkg::*;
#(
    parameter int NUM_REQS       = SMEM_NUM_REQS,
    parameter int WORD_SIZE      = SMEM_WORD_SIZE,
    parameter int TAG_WIDTH      = SMEM_TAG_WIDTH,
    parameter int ADDR_WIDTH     = SMEM_ADDR_WIDTH,
    parameter int SIZE_WORDS     = SMEM_SIZE_WORDS,
    parameter int RSP_QUEUE_SIZE = SMEM_RSP_QUEUE_SIZE
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid,
    input  logic [NUM_REQS-1:0]                req_rw,
    input  logic [NUM_REQS-1:0]                req_is_amo,
    input  logic [NUM_REQS*WORD_SIZE-1:0]      req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]    req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag,
    output logic [NUM_REQS-1:0]                req_ready,
    output logic                               rsp_valid,
    output logic [lane_idx_width(NUM_REQS)-1:0] rsp_lane,
    output logic [WORD_SIZE*8-1:0]             rsp_data,
    output logic [TAG_WIDTH-1:0]               rsp_tag,
    input  logic                               rsp_ready
);

    localparam int LANE_W = lane_idx_width(NUM_REQS);
    localparam int IDX_W  = $clog2(SIZE_WORDS);
    localparam int CRED_W = $clog2(RSP_QUEUE_SIZE) + 1;
    localparam int DATA_W = WORD_SIZE * 8;

    logic [LANE_W-1:0]    rr_ptr;
    logic [LANE_W-1:0]    grant_idx;
    logic [LANE_W-1:0]    grant_nxt;
    logic [LANE_W:0]      cand_sum;
    logic                 grant_found;
    logic                 grant_rd;
    logic                 credit_ok;
    logic                 accept;
    logic                 rd_accept;
    logic                 wr_accept;
    logic [CRED_W-1:0]    credits;
    logic [IDX_W-1:0]     grant_sidx;
    logic [WORD_SIZE-1:0] grant_byteen;
    logic [DATA_W-1:0]    grant_data;
    logic [TAG_WIDTH-1:0] grant_tag;

    logic                 s1_vld;
    logic [LANE_W-1:0]    s1_lane;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [DATA_W-1:0]    s1_data;
    rsp_entry_t           s1_entry;

    logic                 rsp_pop;
    logic                 fifo_push;
    logic                 fifo_empty;
    logic                 fifo_full;
    rsp_entry_t           fifo_head;

    logic [DATA_W-1:0]    mem [SIZE_WORDS];

    // Round-robin search: first valid lane at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand_sum = {1'b0, rr_ptr} + (LANE_W+1)'(i);
            if (cand_sum >= (LANE_W+1)'(NUM_REQS)) begin
                cand_sum = cand_sum - (LANE_W+1)'(NUM_REQS);
            end
            if (!grant_found && req_valid[cand_sum[LANE_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[LANE_W-1:0];
            end
        end
    end

    assign grant_nxt    = (grant_idx == LANE_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_sidx   = req_addr[grant_idx*ADDR_WIDTH +: IDX_W];
    assign grant_byteen = req_byteen[grant_idx*WORD_SIZE +: WORD_SIZE];
    assign grant_data   = req_data[grant_idx*DATA_W +: DATA_W];
    assign grant_tag    = req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH];

    // AMOs are serviced as plain reads, so they consume a credit like a read.
    assign grant_rd  = req_is_amo[grant_idx] | ~req_rw[grant_idx];
    assign credit_ok = (credits < CRED_W'(RSP_QUEUE_SIZE));
    // A credit-blocked grant is not handed to another lane: strict rr order.
    assign accept    = ~reset & grant_found & (~grant_rd | credit_ok);
    assign rd_accept = accept & grant_rd;
    assign wr_accept = accept & ~grant_rd;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Single-port SRAM: at most one access per cycle, so write-then-read of
    // the same word on consecutive cycles sees the new data without bypass.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int b = 0; b < WORD_SIZE; b++) begin
                if (grant_byteen[b]) begin
                    mem[grant_sidx][b*8 +: 8] <= grant_data[b*8 +: 8];
                end
            end
        end
        if (rd_accept) begin
            s1_data <= mem[grant_sidx];
        end
    end

    // Credits count queued responses plus the stage-1 read, so a stage-1
    // entry always has a free slot waiting for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            credits <= '0;
            s1_vld  <= 1'b0;
            s1_lane <= '0;
            s1_tag  <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= grant_nxt;
            end
            case ({rd_accept, rsp_pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
            s1_vld <= rd_accept;
            if (rd_accept) begin
                s1_lane <= grant_idx;
                s1_tag  <= grant_tag;
            end
        end
    end

    assign s1_entry  = '{lane: s1_lane, tag: s1_tag, data: s1_data};
    // The full guard never fires while credits are honoured.
    assign fifo_push = s1_vld & ~fifo_full;
    assign rsp_pop   = rsp_valid & rsp_ready;

    vx_smem_rsp_fifo #(
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (s1_entry),
        .pop       (rsp_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_lane  = fifo_head.lane;
    assign rsp_tag   = fifo_head.tag;
    assign rsp_data  = fifo_head.data;

endmodule

// File: tb/tb_vx_smem_responder.sv
// Randomised and directed bench for vx_smem_responder against a queue/array reference model.
// Latency: model expects each read response exactly visible from accept cycle + 2 onward.
// Backpressure: model admits a read only while outstanding responses < queue depth.
module tb_vx_smem_responder;

    localparam int NR = 4;
    localparam int QD = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_rw;
    logic [3:0]    req_is_amo;
    logic [15:0]   req_byteen;
    logic [119:0]  req_addr;
    logic [127:0]  req_data;
    logic [31:0]   req_tag;
    logic [3:0]    req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_lane;
    logic [31:0]   rsp_data;
    logic [7:0]    rsp_tag;
    logic          rsp_ready;

    vx_smem_responder dut (
        .clk        (clk),
        .reset      (rst),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_is_amo (req_is_amo),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_lane   (rsp_lane),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [7:0] tag;
        logic [31:0] data;
        int         vis;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] m_mem [32];
    int          m_rr;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          acc_count;
    logic [31:0] last_rsp_data;
    logic [7:0]  last_rsp_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_lane(input int l, input logic v, input logic rw, input logic amo,
                            input logic [3:0] be, input logic [29:0] a,
                            input logic [31:0] d, input logic [7:0] t);
        req_valid[l]          = v;
        req_rw[l]             = rw;
        req_is_amo[l]         = amo;
        req_byteen[l*4 +: 4]  = be;
        req_addr[l*30 +: 30]  = a;
        req_data[l*32 +: 32]  = d;
        req_tag[l*8 +: 8]     = t;
    endtask

    task automatic clear_lanes();
        for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 8'h0);
    endtask

    // Random upper address bits above the SRAM index must be ignored.
    function automatic logic [29:0] mk_addr(input int idx);
        return {20'($urandom), 5'b0, 5'(idx)};
    endfunction

    // One clock cycle: compare at negedge against the model, then advance the model.
    task automatic step();
        logic [3:0]  exp_rdy;
        logic        found;
        logic        rd;
        logic        exp_vld;
        int          g;
        int          idx;
        logic [3:0]  be;
        logic [31:0] d;
        exp_t        e;
        @(negedge clk);
        exp_rdy = '0;
        found   = 1'b0;
        g       = 0;
        rd      = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (!found && req_valid[(m_rr + i) % NR]) begin
                    found = 1'b1;
                    g     = (m_rr + i) % NR;
                end
            end
        end
        if (found) begin
            rd = req_is_amo[g] || !req_rw[g];
            if (!rd || exp_q.size() < QD) exp_rdy[g] = 1'b1;
        end
        check("req_ready", req_ready, exp_rdy);
        acc_count += $countones(req_ready);
        exp_vld = !rst && exp_q.size() > 0 && exp_q[0].vis <= cyc;
        check("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) begin
            check("rsp_lane", rsp_lane, exp_q[0].lane);
            check("rsp_tag", rsp_tag, exp_q[0].tag);
            check("rsp_data", rsp_data, exp_q[0].data);
            if (rsp_ready) begin
                last_rsp_data = rsp_data;
                last_rsp_tag  = rsp_tag;
                void'(exp_q.pop_front());
            end
        end
        if (exp_rdy != 4'b0) begin
            idx = int'(req_addr[g*30 +: 5]);
            if (rd) begin
                e.lane = g;
                e.tag  = req_tag[g*8 +: 8];
                e.data = m_mem[idx];
                e.vis  = cyc + 2;
                exp_q.push_back(e);
            end else begin
                be = req_byteen[g*4 +: 4];
                d  = req_data[g*32 +: 32];
                for (int b = 0; b < 4; b++) if (be[b]) m_mem[idx][b*8 +: 8] = d[b*8 +: 8];
            end
            m_rr = (g + 1) % NR;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        m_rr      = 0;
        acc_count = 0;
        last_rsp_data = '0;
        last_rsp_tag  = '0;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_lanes();
        for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 1'b0, 1'b0, 4'hF, 30'h0, 32'h0, 8'h0);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_lane", rsp_lane, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_tag", rsp_tag, 0);
        repeat (2) step();           // req_ready must stay low while in reset
        rst = 1'b0;
        clear_lanes();
        rsp_ready = 1'b1;
        step();

        // Define every SRAM word the bench touches.
        for (int a = 0; a < 32; a++) begin
            set_lane(0, 1'b1, 1'b1, 1'b0, 4'hF, mk_addr(a), $urandom, 8'h0);
            step();
        end
        clear_lanes();

        // Full write then tagged read of 0x10.
        set_lane(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h10, 32'hDEADBEEF, 8'h0);
        step();
        set_lane(0, 1'b1, 1'b0, 1'b0, 4'h0, 30'h10, 32'h0, 8'h5A);
        step();
        clear_lanes();
        repeat (3) step();
        check("t1_data", last_rsp_data, 32'hDEADBEEF);
        check("t1_tag", last_rsp_tag, 8'h5A);

        // Partial byte-enable write over 0xAAAAAAAA.
        set_lane(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h10, 32'hAAAAAAAA, 8'h0);
        step();
        set_lane(0, 1'b1, 1'b1, 1'b0, 4'b0101, 30'h10, 32'h11223344, 8'h0);
        step();
        set_lane(0, 1'b1, 1'b0, 1'b0, 4'h0, 30'h10, 32'h0, 8'h77);
        step();
        clear_lanes();
        repeat (3) step();
        check("t2_partial", last_rsp_data, 32'hAA22AA44);

        // All lanes reading continuously with rsp_ready=1.
        for (int c = 0; c < 16; c++) begin
            for (int l = 0; l < NR; l++)
                set_lane(l, 1'b1, 1'b0, 1'b0, 4'h0, mk_addr($urandom_range(31)), 32'h0, 8'(l*16 + c));
            step();
        end
        clear_lanes();
        repeat (4) step();

        // Credit exhaustion with rsp_ready=0, then drain.
        rsp_ready = 1'b0;
        acc_count = 0;
        for (int c = 0; c < 8; c++) begin
            for (int l = 0; l < NR; l++)
                set_lane(l, 1'b1, 1'b0, 1'b0, 4'h0, mk_addr($urandom_range(31)), 32'h0, 8'($urandom));
            step();
        end
        check("t4_accepted", acc_count, 4);
        rsp_ready = 1'b1;
        acc_count = 0;
        repeat (6) step();
        clear_lanes();
        repeat (8) step();

        // Write then read on another lane next cycle; AMO must not modify memory.
        set_lane(0, 1'b1, 1'b1, 1'b0, 4'hF, 30'h3, 32'hCAFEF00D, 8'h0);
        step();
        clear_lanes();
        set_lane(1, 1'b1, 1'b0, 1'b0, 4'h0, 30'h3, 32'h0, 8'h31);
        step();
        clear_lanes();
        set_lane(2, 1'b1, 1'b1, 1'b1, 4'hF, 30'h3, 32'h12345678, 8'h32);
        step();
        clear_lanes();
        set_lane(3, 1'b1, 1'b0, 1'b0, 4'h0, 30'h3, 32'h0, 8'h33);
        step();
        clear_lanes();
        repeat (4) step();
        check("t5_amo_nowrite", last_rsp_data, 32'hCAFEF00D);
        check("t5_last_tag", last_rsp_tag, 8'h33);

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            for (int l = 0; l < NR; l++)
                set_lane(l, 1'($urandom_range(99) < 50), 1'($urandom_range(1)),
                         1'($urandom_range(9) == 0), 4'($urandom),
                         mk_addr($urandom_range(31)), $urandom, 8'($urandom));
            rsp_ready = 1'($urandom_range(99) < 70);
            step();
        end
        clear_lanes();
        rsp_ready = 1'b1;
        repeat (8) step();

        // Reset with responses queued.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < NR; l++)
                set_lane(l, 1'b1, 1'b0, 1'b0, 4'h0, mk_addr($urandom_range(31)), 32'h0, 8'($urandom));
            step();
        end
        clear_lanes();
        repeat (3) step();
        rst = 1'b1;
        exp_q.delete();
        m_rr = 0;
        #1;
        check("t6_rsp_valid_reset", rsp_valid, 0);
        check("t6_rsp_tag_reset", rsp_tag, 0);
        repeat (2) step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) step();
        acc_count = 0;
        for (int l = 0; l < NR; l++)
            set_lane(l, 1'b1, 1'b0, 1'b0, 4'h0, mk_addr($urandom_range(31)), 32'h0, 8'(8'hA0 + l));
        step();
        check("t6_rr_restart", acc_count, 1);
        clear_lanes();
        repeat (4) step();
        check("t6_first_lane", last_rsp_tag, 8'hA0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
